// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: ctrl encodings and default width.
// The rotate option is selected by the USR_ROTATE_EN macro (see usr_next_val).
package usr_pkg;

  localparam int USR_WIDTH = 8;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHR  = 2'b01;
  localparam logic [1:0] CTRL_SHL  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-state logic for the universal shift register.
// Build option USR_ROTATE_EN: shifts rotate the outgoing bit back in instead of filling with 0.
module usr_next_val
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH
) (
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] nxt
);

  logic fill_r;
  logic fill_l;

`ifdef USR_ROTATE_EN
  assign fill_r = q[0];
  assign fill_l = q[WIDTH-1];
`else
  assign fill_r = 1'b0;
  assign fill_l = 1'b0;
`endif

  // Undecodable ctrl drives X so a bad select is visible in simulation.
  always_comb begin
    nxt = q;
    case (ctrl)
      CTRL_HOLD: nxt = q;
      CTRL_SHR:  nxt = {fill_r, q[WIDTH-1:1]};
      CTRL_SHL:  nxt = {q[WIDTH-2:0], fill_l};
      CTRL_LOAD: nxt = d;
      default:   nxt = 'x;
    endcase
  end

endmodule

// File: rtl/usr.sv
// Universal shift register: hold / shift right / shift left / parallel load, 1-cycle latency.
// Rotate behaviour enabled by defining USR_ROTATE_EN; ports and timing are unchanged by it.
module usr
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] nxt;

  usr_next_val #(.WIDTH(WIDTH)) u_next (
    .ctrl (ctrl),
    .q    (q),
    .d    (d),
    .nxt  (nxt)
  );

  // Active-low async reset wins over any operation, including a load on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= nxt;
  end

endmodule

// File: tb/tb_usr.sv
// Self-checking bench for usr: table of directed vectors plus hand-written reset sequences.
// Expected values switch with USR_ROTATE_EN to match the rotate build.
module tb_usr;
  import usr_pkg::*;

  typedef struct {
    string      name;
    logic [1:0] ctrl;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] ctrl;
  logic [7:0] d;
  logic [7:0] q;

  int nChecks = 0;
  int nFails  = 0;

  vec_t vecs[$];

  usr #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl),
    .d     (d),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, q=%h required finish", q);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] exp);
    nChecks++;
    if (q !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: q=%h required %h", name, q, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge act, sample 1 time unit later.
  task automatic applyStimulus(input logic [1:0] c, input logic [7:0] dv);
    @(negedge clk);
    ctrl = c;
    d    = dv;
    @(posedge clk);
    #1;
  endtask

  function automatic void addVec(input string n, input logic [1:0] c,
                                 input logic [7:0] dv, input logic [7:0] e);
    vec_t v;
    v.name = n;
    v.ctrl = c;
    v.d    = dv;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] shlExp;

    addVec("load_d3", CTRL_LOAD, 8'hD3, 8'hD3);
    addVec("hold_1",  CTRL_HOLD, 8'h00, 8'hD3);
    addVec("hold_2",  CTRL_HOLD, 8'hFF, 8'hD3);
    addVec("hold_3",  CTRL_HOLD, 8'h5A, 8'hD3);
`ifdef USR_ROTATE_EN
    addVec("shr_d3",  CTRL_SHR,  8'hAA, 8'hE9);
    addVec("shl_e9",  CTRL_SHL,  8'h55, 8'hD3);
`else
    addVec("shr_d3",  CTRL_SHR,  8'hAA, 8'h69);
    addVec("shl_69",  CTRL_SHL,  8'h55, 8'hD2);
`endif
    addVec("load_ff", CTRL_LOAD, 8'hFF, 8'hFF);
    shlExp = 8'hFF;
    for (int i = 0; i < 8; i++) begin
`ifndef USR_ROTATE_EN
      shlExp = {shlExp[6:0], 1'b0};
`endif
      addVec($sformatf("shl_ff_%0d", i + 1), CTRL_SHL, 8'h00, shlExp);
    end
    addVec("load_81", CTRL_LOAD, 8'h81, 8'h81);
`ifdef USR_ROTATE_EN
    addVec("shr_81",  CTRL_SHR,  8'h00, 8'hC0);
    addVec("shl_c0",  CTRL_SHL,  8'h00, 8'h81);
`else
    addVec("shr_81",  CTRL_SHR,  8'h00, 8'h40);
    addVec("shl_40",  CTRL_SHL,  8'h00, 8'h80);
`endif

    // Reset held low with a load pending: q must stay zero.
    reset = 1'b0;
    ctrl  = CTRL_LOAD;
    d     = 8'hD3;
    #1;
    checkOutput("reset_initial", 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset_hold_%0d", i), 8'h00);
    end

    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ctrl, vecs[i].d);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Mid-cycle reset clears q immediately, then a load works on the first edge after release.
    applyStimulus(CTRL_LOAD, 8'hD3);
    checkOutput("reload_d3", 8'hD3);
    ctrl = CTRL_LOAD;
    d    = 8'hFF;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_clear", 8'h00);
    @(posedge clk);
    #1;
    checkOutput("reset_over_load", 8'h00);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(CTRL_LOAD, 8'h5A);
    checkOutput("load_5a_after_reset", 8'h5A);
    applyStimulus(CTRL_HOLD, 8'hC3);
    checkOutput("hold_5a", 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/usr.md
USR -- requirements
Module: usr

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..64).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-004 The module SHALL have port ctrl, input, 2 bits, the operation select.
REQ-005 The module SHALL have port d, input, WIDTH bits, the parallel load data.
REQ-006 The module SHALL have port q, output, WIDTH bits, the register contents, driven directly from flops.

Function
REQ-007 ctrl=00 SHALL hold: q is unchanged at the rising edge.
REQ-008 ctrl=01 SHALL shift right: q <= {fill, q[WIDTH-1:1]}, where fill is 0 in the default build.
REQ-009 ctrl=10 SHALL shift left: q <= {q[WIDTH-2:0], fill}, where fill is 0 in the default build.
REQ-010 ctrl=11 SHALL parallel-load: q <= d.
REQ-011 Every operation SHALL have 1-cycle latency: the new q is visible immediately after the rising edge that sampled ctrl and d.
REQ-012 d SHALL be ignored unless ctrl=11.
REQ-013 The module SHALL have no handshake; a new operation is accepted on every clock edge.
REQ-014 Unknown or X ctrl values SHALL NOT be decoded; in simulation q SHALL go to all-X for them.
REQ-015 Bits shifted out of q SHALL be discarded in the default build.

Reset
REQ-016 While reset=0, q SHALL be all zeros, asynchronously and independent of clk.
REQ-017 Reset SHALL take priority over every ctrl operation, including a load on the same edge.
REQ-018 Reset asserted mid-operation SHALL clear q immediately.
REQ-019 After reset deasserts, operation SHALL resume on the first rising edge at which reset=1.

Configuration
REQ-020 The macro USR_ROTATE_EN SHALL control whether shifts rotate.
REQ-021 With USR_ROTATE_EN defined, the fill bit SHALL be the bit shifted out: q[0] for a right shift and q[WIDTH-1] for a left shift.
REQ-022 With USR_ROTATE_EN undefined, the fill bit SHALL be 0.
REQ-023 The macro SHALL affect only the fill bit; ports, timing and reset behaviour SHALL be identical in both builds.

Structure
REQ-024 A shared package usr_pkg SHALL hold the ctrl encoding constants and the default WIDTH.
- ctrl constants: CTRL_HOLD=2'b00, CTRL_SHR=2'b01, CTRL_SHL=2'b10, CTRL_LOAD=2'b11.
REQ-025 A combinational sub-module usr_next_val SHALL compute the next register value from q, d, ctrl and the fill selection.
REQ-026 usr SHALL contain only the register, the reset logic and one instance of usr_next_val.

Verification
REQ-027 The bench SHALL hold reset=0 for several edges with ctrl=11 and d=8'hD3 -> q=8'h00 throughout.
REQ-028 The bench SHALL release reset, then apply ctrl=11 with d=8'hD3 -> q=8'b11010011 after one edge; then ctrl=00 for 3 edges -> q stays 8'hD3.
REQ-029 From q=8'hD3, the bench SHALL apply ctrl=01 -> q=8'b01101001, then ctrl=10 -> q=8'b11010010 (default build).
REQ-030 With USR_ROTATE_EN defined, from q=8'hD3 the bench SHALL apply ctrl=01 -> q=8'b11101001, then ctrl=10 -> q=8'hD3.
REQ-031 The bench SHALL load 8'hFF and then shift left 8 times -> q=8'h00 (default build) and q=8'hFF (rotate build).
REQ-032 The bench SHALL assert reset low between clock edges while q=8'hD3 -> q=8'h00 before the next edge, then release and apply ctrl=11 with d=8'h5A -> q=8'h5A.
